axi_ar_router: RTL and testbench
================================

AXI_AR_ROUTER -- requirements
Module: axi_ar_router

Interface
REQ-001 SHALL have parameter NB_MASTER, default 9: number of downstream target ports.
REQ-002 SHALL have parameter NB_SLAVE, default 2: number of upstream initiator ports.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 64: address width.
REQ-004 SHALL have parameter AXI_ID_WIDTH, default 4: inbound ID width.
REQ-005 SHALL have parameter MAX_TXNS, default 4: outstanding-request limit per initiator, range 1..255.
REQ-006 SHALL derive SIDX_W = max(1, clog2(NB_SLAVE)) and AXI_ID_OUT = AXI_ID_WIDTH + SIDX_W.
REQ-007 SHALL use one clock and an asynchronous, active-high reset.
REQ-008 SHALL provide these ports, all synchronous to clk:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_addr_i  in  NB_MASTER x AXI_ADDR_WIDTH  region base, inclusive.
- end_addr_i  in  NB_MASTER x AXI_ADDR_WIDTH  region limit, inclusive.
- slv_valid_i  in  NB_SLAVE  request valid.
- slv_ready_o  out  NB_SLAVE  request accepted.
- slv_addr_i  in  NB_SLAVE x AXI_ADDR_WIDTH  request address.
- slv_id_i  in  NB_SLAVE x AXI_ID_WIDTH  request ID.
- slv_done_i  in  NB_SLAVE  one-cycle pulse: one transaction of that initiator completed.
- mst_valid_o  out  NB_MASTER  routed request valid.
- mst_ready_i  in  NB_MASTER  target accepts.
- mst_addr_o  out  NB_MASTER x AXI_ADDR_WIDTH  routed address.
- mst_id_o  out  NB_MASTER x AXI_ID_OUT  extended ID.
- err_valid_o  out  1  decode-miss request valid.
- err_ready_i  in  1  error sink accepts.
- err_id_o  out  AXI_ID_OUT  extended ID of the miss.

Function
REQ-009 SHALL decode each request to the lowest target index m with start_addr_i[m] <= addr <= end_addr_i[m]; if none matches, SHALL route to the error port. The error port counts as target NB_MASTER.
REQ-010 SHALL treat an initiator as eligible when slv_valid_i=1 and its outstanding count < MAX_TXNS.
REQ-011 SHALL provide one round-robin arbiter per target (NB_MASTER+1 arbiters) over eligible initiators decoding to that target.
REQ-012 After a grant to initiator k, each arbiter SHALL give highest priority to k+1 (mod NB_SLAVE); its pointer SHALL move only on an accepted handshake.
REQ-013 SHALL give each target a one-entry output register. The register can load when it is empty, or when it is full and its ready input is 1 in the same cycle.
REQ-014 slv_ready_o[k] SHALL be 1 only when k is granted by its target's arbiter and that register can load; it SHALL NOT depend combinationally on slv_valid_i[k] beyond arbitration.
REQ-015 On slv_valid_i[k]&slv_ready_o[k], the register SHALL capture addr and ID={k[SIDX_W-1:0], slv_id_i[k]}, and valid SHALL assert on the next cycle (latency 1).
REQ-016 mst_valid_o/err_valid_o SHALL, once set, hold valid, addr and ID stable until their ready input is 1; full throughput of one request per cycle per target SHALL be sustained.
REQ-017 err_valid_o, err_ready_i and err_id_o SHALL follow the same handshake; the error port SHALL carry no address.
REQ-018 Outstanding count per initiator: +1 on accept, -1 on slv_done_i; both in the same cycle leaves it unchanged; slv_done_i at count 0 SHALL be ignored (no underflow).
REQ-019 Different initiators targeting different targets SHALL be granted in the same cycle independently.
REQ-020 The memory map inputs are sampled combinationally at decode; changes affect only not-yet-accepted requests.

Reset
REQ-021 While rst=1, all output registers SHALL be empty: mst_valid_o=0, err_valid_o=0, slv_ready_o=0.
REQ-022 While rst=1, mst_addr_o, mst_id_o and err_id_o SHALL be 0, all arbiter pointers SHALL select initiator 0, and all outstanding counts SHALL be 0.
REQ-023 Reset asserted mid-transfer SHALL discard in-flight register contents immediately (asynchronous); no request is replayed after deassertion.

Verification
REQ-024 Map m0=0x0000-0x0FFF, m1=0x1000-0x1FFF. Slave0 sends addr 0x1004, id 3 with mst_ready_i=1 -> mst_valid_o[1]=1 one cycle later, addr 0x1004, mst_id_o[1]=0x03.
REQ-025 Both slaves send continuously to m0 with ready=1 -> grants alternate 0,1,0,1; mst_id_o MSB alternates; one transfer per cycle.
REQ-026 Slave1 sends addr 0x8000 (unmapped), id 5 -> err_valid_o=1 next cycle with err_id_o=0x15; err_ready_i=0 for 3 cycles -> err_id_o stable and slv_ready_o[1]=0 for a second miss.
REQ-027 MAX_TXNS=4, slave0 issues 4 requests with no done -> 5th has slv_ready_o[0]=0; one slv_done_i pulse -> 5th accepted next cycle; done plus accept in one cycle -> count stays 4.
REQ-028 mst_ready_i[0]=0 with a request held, then rst pulsed -> mst_valid_o[0]=0 immediately, all counts 0, and the first grant after reset goes to slave0.

Source files
------------

// File: rtl/axi_ar_router.sv
// AXI read-address router: decodes initiator requests onto target ports.
// Each target has a round-robin arbiter and a one-entry output register.
module axi_ar_router #(
  parameter int NB_MASTER      = 9,
  parameter int NB_SLAVE       = 2,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MAX_TXNS       = 4,
  localparam int SIDX_W     = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1,
  localparam int AXI_ID_OUT = AXI_ID_WIDTH + SIDX_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] end_addr_i,
  input  logic [NB_SLAVE-1:0]                      slv_valid_i,
  output logic [NB_SLAVE-1:0]                      slv_ready_o,
  input  logic [NB_SLAVE-1:0][AXI_ADDR_WIDTH-1:0]  slv_addr_i,
  input  logic [NB_SLAVE-1:0][AXI_ID_WIDTH-1:0]    slv_id_i,
  input  logic [NB_SLAVE-1:0]                      slv_done_i,
  output logic [NB_MASTER-1:0]                     mst_valid_o,
  input  logic [NB_MASTER-1:0]                     mst_ready_i,
  output logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] mst_addr_o,
  output logic [NB_MASTER-1:0][AXI_ID_OUT-1:0]     mst_id_o,
  output logic                                     err_valid_o,
  input  logic                                     err_ready_i,
  output logic [AXI_ID_OUT-1:0]                    err_id_o
);

  localparam int NT = NB_MASTER + 1;
  localparam int TW = $clog2(NT);
  localparam int CW = 8;

  logic [NB_SLAVE-1:0][TW-1:0]             dec;
  logic [NB_SLAVE-1:0]                     elig;
  logic [NT-1:0][NB_SLAVE-1:0]             gnt;
  logic [NT-1:0]                           rdy;
  logic [NT-1:0]                           can_load;
  logic [NB_SLAVE-1:0]                     acc;

  logic [NT-1:0]                           full_q, full_d;
  logic [NT-1:0][AXI_ID_OUT-1:0]           id_q, id_d;
  logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NT-1:0][SIDX_W-1:0]               ptr_q, ptr_d;
  logic [NB_SLAVE-1:0][CW-1:0]             cnt_q, cnt_d;

  // Lowest matching region wins; no match selects the error port.
  always_comb begin
    for (int k = 0; k < NB_SLAVE; k++) begin
      dec[k] = TW'(NB_MASTER);
      for (int m = NB_MASTER - 1; m >= 0; m--) begin
        if (slv_addr_i[k] >= start_addr_i[m] &&
            slv_addr_i[k] <= end_addr_i[m])
          dec[k] = TW'(m);
      end
    end
  end

  always_comb begin
    elig = '0;
    for (int k = 0; k < NB_SLAVE; k++)
      elig[k] = slv_valid_i[k] && (cnt_q[k] < CW'(MAX_TXNS));
  end

  always_comb begin : arb
    logic found;
    int   idx;
    gnt = '0;
    for (int t = 0; t < NT; t++) begin
      found = 1'b0;
      for (int i = 0; i < NB_SLAVE; i++) begin
        idx = (int'(ptr_q[t]) + i) % NB_SLAVE;
        if (!found && elig[idx] && dec[idx] == TW'(t)) begin
          gnt[t][idx] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  assign rdy      = {err_ready_i, mst_ready_i};
  assign can_load = ~full_q | rdy;

  always_comb begin
    slv_ready_o = '0;
    for (int k = 0; k < NB_SLAVE; k++)
      slv_ready_o[k] = !rst && gnt[dec[k]][k] && can_load[dec[k]];
  end

  assign acc = slv_valid_i & slv_ready_o;

  always_comb begin
    full_d = full_q & ~rdy;
    id_d   = id_q;
    ptr_d  = ptr_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    for (int t = 0; t < NT; t++) begin
      for (int k = 0; k < NB_SLAVE; k++) begin
        if (acc[k] && dec[k] == TW'(t)) begin
          full_d[t] = 1'b1;
          id_d[t]   = {SIDX_W'(k), slv_id_i[k]};
          ptr_d[t]  = SIDX_W'((k + 1) % NB_SLAVE);
        end
      end
    end
    for (int t = 0; t < NB_MASTER; t++) begin
      for (int k = 0; k < NB_SLAVE; k++) begin
        if (acc[k] && dec[k] == TW'(t))
          addr_d[t] = slv_addr_i[k];
      end
    end
    // Done at zero is dropped so the count never wraps.
    for (int k = 0; k < NB_SLAVE; k++)
      cnt_d[k] = cnt_q[k] + CW'(acc[k])
               - CW'(slv_done_i[k] && cnt_q[k] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      id_q   <= '0;
      addr_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      id_q   <= id_d;
      addr_q <= addr_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mst_valid_o = full_q[NB_MASTER-1:0];
  assign mst_addr_o  = addr_q;
  assign mst_id_o    = id_q[NB_MASTER-1:0];
  assign err_valid_o = full_q[NB_MASTER];
  assign err_id_o    = id_q[NB_MASTER];

endmodule

// File: tb/tb_axi_ar_router.sv
// Scoreboard bench for axi_ar_router: accepted requests are queued per
// target, a negedge monitor pops and compares on every output handshake.
module tb_axi_ar_router;

  localparam int NM = 9;
  localparam int NS = 2;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int IO = 5;

  typedef struct packed {
    logic [IO-1:0] id;
    logic [AW-1:0] addr;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NM-1:0][AW-1:0]  start_a, end_a;
  logic [NS-1:0]          slv_valid, slv_ready, slv_done;
  logic [NS-1:0][AW-1:0]  slv_addr;
  logic [NS-1:0][IW-1:0]  slv_id;
  logic [NM-1:0]          mst_valid, mst_ready;
  logic [NM-1:0][AW-1:0]  mst_addr;
  logic [NM-1:0][IO-1:0]  mst_id;
  logic                   err_valid, err_ready;
  logic [IO-1:0]          err_id;

  exp_t          sb [0:NM][$];
  int            exp_tgt [NS];
  logic [IO-1:0] exp_id [NS];
  logic [AW-1:0] exp_addr [NS];
  int            errors = 0;
  int            checks = 0;

  axi_ar_router dut (
    .clk(clk), .rst(rst),
    .start_addr_i(start_a), .end_addr_i(end_a),
    .slv_valid_i(slv_valid), .slv_ready_o(slv_ready),
    .slv_addr_i(slv_addr), .slv_id_i(slv_id), .slv_done_i(slv_done),
    .mst_valid_o(mst_valid), .mst_ready_i(mst_ready),
    .mst_addr_o(mst_addr), .mst_id_o(mst_id),
    .err_valid_o(err_valid), .err_ready_i(err_ready), .err_id_o(err_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act,
                     input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int t = 0; t <= NM; t++) begin
        logic v, r;
        logic [IO-1:0] id;
        logic [AW-1:0] a;
        exp_t e;
        if (t < NM) begin
          v = mst_valid[t]; r = mst_ready[t];
          id = mst_id[t]; a = mst_addr[t];
        end else begin
          v = err_valid; r = err_ready; id = err_id; a = '0;
        end
        if (v && r) begin
          if (sb[t].size() == 0) begin
            chk($sformatf("unexpected out t%0d", t), 1, 0);
          end else begin
            e = sb[t].pop_front();
            chk($sformatf("id t%0d", t), AW'(id), AW'(e.id));
            if (t < NM)
              chk($sformatf("addr t%0d", t), a, e.addr);
          end
        end
      end
      for (int k = 0; k < NS; k++)
        if (slv_valid[k] && slv_ready[k])
          sb[exp_tgt[k]].push_back('{exp_id[k], exp_addr[k]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int k, input logic [AW-1:0] a,
                       input logic [IW-1:0] id, input int tgt,
                       input logic [IO-1:0] eid);
    slv_valid[k] = 1'b1;
    slv_addr[k]  = a;
    slv_id[k]    = id;
    exp_tgt[k]   = tgt;
    exp_id[k]    = eid;
    exp_addr[k]  = a;
  endtask

  task automatic send(input int k, input logic [AW-1:0] a,
                      input logic [IW-1:0] id, input int tgt,
                      input logic [IO-1:0] eid);
    logic ok;
    setup(k, a, id, tgt, eid);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = slv_ready[k];
    end
    chk($sformatf("send accept s%0d", k), AW'(ok), 1);
    step();
    slv_valid[k] = 1'b0;
  endtask

  task automatic burst_check(input int k, input int n_ok, input int n_blk);
    for (int i = 0; i < n_ok + n_blk; i++) begin
      @(negedge clk);
      chk($sformatf("burst s%0d cyc%0d", k, i),
          AW'(slv_ready[k]), AW'(i < n_ok));
      step();
    end
  endtask

  task automatic drain();
    slv_done = '1;
    repeat (6) step();
    slv_done = '0;
  endtask

  initial begin
    start_a[0] = 64'h0000; end_a[0] = 64'h0FFF;
    start_a[1] = 64'h1000; end_a[1] = 64'h1FFF;
    for (int m = 2; m < NM; m++) begin
      start_a[m] = 64'(m) << 16;
      end_a[m]   = (64'(m) << 16) + 64'hFFF;
    end
    rst = 1'b1; mst_ready = '1; err_ready = 1'b1; slv_done = '0;
    slv_valid = '1; slv_addr = '0; slv_id = '0;
    for (int k = 0; k < NS; k++) begin
      exp_tgt[k] = 0; exp_id[k] = '0; exp_addr[k] = '0;
    end

    // reset state with requests presented
    repeat (2) step();
    @(negedge clk);
    chk("rst slv_ready", AW'(slv_ready), 0);
    chk("rst mst_valid", AW'(mst_valid), 0);
    chk("rst err_valid", AW'(err_valid), 0);
    chk("rst mst_addr nz", AW'(mst_addr != '0), 0);
    chk("rst mst_id nz", AW'(mst_id != '0), 0);
    chk("rst err_id", AW'(err_id), 0);
    slv_valid = '0;
    step();
    rst = 1'b0;
    step();

    // basic decode and latency
    send(0, 64'h1004, 4'd3, 1, 5'h03);
    @(negedge clk);
    chk("lat valid m1", AW'(mst_valid[1]), 1);
    chk("lat addr m1", mst_addr[1], 64'h1004);
    chk("lat id m1", AW'(mst_id[1]), 5'h03);
    step();
    drain();

    // contention on m0: alternating grants, one per cycle
    slv_done = '1;
    setup(0, 64'h100, 4'd2, 0, 5'h02);
    setup(1, 64'h200, 4'd7, 0, 5'h17);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("alt ready cyc%0d", i), AW'(slv_ready),
          (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i > 0) chk($sformatf("alt thru cyc%0d", i), AW'(mst_valid[0]), 1);
      step();
    end
    slv_valid = '0;
    drain();

    // decode miss with error sink stalled
    err_ready = 1'b0;
    send(1, 64'h8000, 4'd5, NM, 5'h15);
    @(negedge clk);
    chk("err valid", AW'(err_valid), 1);
    chk("err id", AW'(err_id), 5'h15);
    step();
    setup(1, 64'h9000, 4'd6, NM, 5'h16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("err hold id cyc%0d", i), AW'(err_id), 5'h15);
      chk($sformatf("err hold valid cyc%0d", i), AW'(err_valid), 1);
      chk($sformatf("err block cyc%0d", i), AW'(slv_ready[1]), 0);
      step();
    end
    err_ready = 1'b1;
    @(negedge clk);
    chk("err reload ready", AW'(slv_ready[1]), 1);
    step();
    slv_valid[1] = 1'b0;
    @(negedge clk);
    chk("err second id", AW'(err_id), 5'h16);
    chk("err second valid", AW'(err_valid), 1);
    step();
    drain();

    // outstanding limit
    setup(0, 64'h20000, 4'd1, 2, 5'h01);
    burst_check(0, 4, 3);
    slv_done[0] = 1'b1;
    @(negedge clk);
    chk("lim done cycle", AW'(slv_ready[0]), 0);
    step();
    @(negedge clk);
    chk("lim after done", AW'(slv_ready[0]), 1);
    step();
    slv_done[0] = 1'b0;
    @(negedge clk);
    chk("lim done+acc", AW'(slv_ready[0]), 1);
    step();
    @(negedge clk);
    chk("lim full again", AW'(slv_ready[0]), 0);
    step();
    slv_valid = '0;
    drain();
    setup(0, 64'h20010, 4'd1, 2, 5'h01);
    burst_check(0, 4, 1);
    slv_valid = '0;
    drain();

    // reset mid-transfer
    mst_ready[0] = 1'b0;
    setup(0, 64'h20020, 4'd1, 2, 5'h01);
    burst_check(0, 3, 0);
    send(0, 64'h40, 4'd4, 0, 5'h04);
    @(negedge clk);
    chk("held m0", AW'(mst_valid[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async clr m0", AW'(mst_valid[0]), 0);
    chk("async clr ready", AW'(slv_ready), 0);
    for (int t = 0; t <= NM; t++) sb[t].delete();
    repeat (2) step();
    rst = 1'b0;
    mst_ready = '1;
    setup(0, 64'h300, 4'd9, 0, 5'h09);
    setup(1, 64'h400, 4'd10, 0, 5'h1A);
    @(negedge clk);
    chk("post rst grant", AW'(slv_ready), 64'h1);
    step();
    slv_valid[1] = 1'b0;
    burst_check(0, 3, 1);
    slv_valid = '0;
    drain();

    begin
      int left;
      left = 0;
      for (int t = 0; t <= NM; t++) left += sb[t].size();
      chk("scoreboard empty", AW'(left), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
